// File: rtl/trace_chk_pkg.sv
// Shared types and constants for the CPU trace line checker: FSM states,
// format codes, error-bit indices and the ASCII punctuation it recognises.
package trace_chk_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    HAT     = 4'd1,
    TIME    = 4'd2,
    AT      = 4'd3,
    PC      = 4'd4,
    COLON   = 4'd5,
    DOLLAR  = 4'd6,
    GRF     = 4'd7,
    GRF_SP  = 4'd8,
    STAR    = 4'd9,
    ADDR    = 4'd10,
    ADDR_SP = 4'd11,
    LT      = 4'd12,
    EQ      = 4'd13,
    DATA    = 4'd14,
    END     = 4'd15
  } state_e;

  localparam logic [1:0] FMT_NONE = 2'b00;
  localparam logic [1:0] FMT_REG  = 2'b01;
  localparam logic [1:0] FMT_MEM  = 2'b10;

  localparam int ERR_PC_RANGE   = 0;
  localparam int ERR_PC_ALIGN   = 1;
  localparam int ERR_ADDR_ALIGN = 2;
  localparam int ERR_GRF        = 3;

  localparam logic [7:0] CH_HAT    = 8'h5e;
  localparam logic [7:0] CH_AT     = 8'h40;
  localparam logic [7:0] CH_COLON  = 8'h3a;
  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2a;
  localparam logic [7:0] CH_LT     = 8'h3c;
  localparam logic [7:0] CH_EQ     = 8'h3d;
  localparam logic [7:0] CH_HASH   = 8'h23;

  // Decimal accumulate step for the GRF index, clamped to 127.
  function automatic logic [6:0] grf_step(input logic [6:0] acc, input logic [3:0] d);
    logic [10:0] v;
    v = (11'(acc) * 11'd10) + 11'(d);
    if (v > 11'd127) begin
      return 7'd127;
    end else begin
      return v[6:0];
    end
  endfunction

endpackage

// File: rtl/trace_line_checker_char_class.sv
// Combinational ASCII classifier: decimal digit, lowercase hex digit and
// the 4-bit value of that digit.
module char_class (
  input  logic [7:0] char,
  output logic       is_dec,
  output logic       is_hex,
  output logic [3:0] nibble
);

  // Classify the incoming character; uppercase hex is deliberately rejected.
  always_comb begin
    is_dec = 1'b0;
    is_hex = 1'b0;
    nibble = 4'h0;
    if ((char >= 8'h30) && (char <= 8'h39)) begin
      is_dec = 1'b1;
      is_hex = 1'b1;
      nibble = char[3:0];
    end else if ((char >= 8'h61) && (char <= 8'h66)) begin
      is_hex = 1'b1;
      nibble = char[3:0] + 4'd9;
    end else begin
      is_dec = 1'b0;
      is_hex = 1'b0;
      nibble = 4'h0;
    end
  end

endmodule

// File: rtl/trace_line_checker.sv
// Character-serial checker for register-write and memory-write trace lines:
// syntax FSM, semantic flags and a saturating count of clean lines.
module trace_line_checker
  import trace_chk_pkg::*;
#(
  parameter int          TIME_MAX_DIGITS = 4,
  parameter int          PC_DIGITS       = 8,
  parameter int          ADDR_DIGITS     = 8,
  parameter int          DATA_DIGITS     = 8,
  parameter int          GRF_MAX_DIGITS  = 4,
  parameter logic [31:0] PC_MIN          = 32'h0000_3000,
  parameter logic [31:0] PC_MAX          = 32'h0000_6ffc,
  parameter int          CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       char,
  output logic [1:0]       format_type,
  output logic [3:0]       error_code,
  output logic [CNT_W-1:0] line_count
);

  localparam int              PC_W     = 4 * PC_DIGITS;
  localparam logic [PC_W-1:0] PC_LO    = PC_W'(PC_MIN);
  localparam logic [PC_W-1:0] PC_HI    = PC_W'(PC_MAX);
  localparam logic [7:0]      TIME_MAX = 8'(TIME_MAX_DIGITS);
  localparam logic [7:0]      PC_N     = 8'(PC_DIGITS);
  localparam logic [7:0]      ADDR_N   = 8'(ADDR_DIGITS);
  localparam logic [7:0]      DATA_N   = 8'(DATA_DIGITS);
  localparam logic [7:0]      GRF_MAX  = 8'(GRF_MAX_DIGITS);

  state_e           state_r, state_s;
  logic [7:0]       cnt_r, cnt_s;
  logic [PC_W-1:0]  pc_r, pc_s;
  logic [6:0]       grf_r, grf_s;
  logic [1:0]       addr_lo_r, addr_lo_s;
  logic [1:0]       type_r, type_s;
  logic [3:0]       flags_s;
  logic [1:0]       fmt_r;
  logic [3:0]       err_r;
  logic [CNT_W-1:0] count_r;
  logic             is_dec_s, is_hex_s;
  logic [3:0]       nibble_s;

  char_class u_char_class (
    .char   (char),
    .is_dec (is_dec_s),
    .is_hex (is_hex_s),
    .nibble (nibble_s)
  );

  // Next-state and field-accumulator logic; '^' always restarts a line.
  always_comb begin
    state_s   = IDLE;
    cnt_s     = cnt_r;
    pc_s      = pc_r;
    grf_s     = grf_r;
    addr_lo_s = addr_lo_r;
    type_s    = type_r;
    if (char == CH_HAT) begin
      state_s   = HAT;
      cnt_s     = 8'd0;
      pc_s      = {PC_W{1'b0}};
      grf_s     = 7'd0;
      addr_lo_s = 2'b00;
      type_s    = FMT_NONE;
    end else begin
      case (state_r)
        HAT: begin
          if (is_dec_s) begin state_s = TIME; cnt_s = 8'd1; end
          else          begin state_s = IDLE; end
        end
        TIME: begin
          if (is_dec_s && (cnt_r < TIME_MAX)) begin state_s = TIME; cnt_s = cnt_r + 8'd1; end
          else if (!is_dec_s && (char == CH_AT)) begin state_s = AT; cnt_s = 8'd0; end
          else begin state_s = IDLE; end
        end
        AT: begin
          if (is_hex_s) begin state_s = PC; cnt_s = 8'd1; pc_s = PC_W'(nibble_s); end
          else          begin state_s = IDLE; end
        end
        PC: begin
          if (is_hex_s && (cnt_r < PC_N)) begin
            state_s = PC;
            cnt_s   = cnt_r + 8'd1;
            pc_s    = (pc_r << 4) | PC_W'(nibble_s);
          end else if ((char == CH_COLON) && (cnt_r == PC_N)) begin
            state_s = COLON;
            cnt_s   = 8'd0;
          end else begin
            state_s = IDLE;
          end
        end
        COLON: begin
          if (char == CH_SPACE)       begin state_s = COLON; end
          else if (char == CH_DOLLAR) begin state_s = DOLLAR; type_s = FMT_REG; end
          else if (char == CH_STAR)   begin state_s = STAR;   type_s = FMT_MEM; end
          else                        begin state_s = IDLE; end
        end
        DOLLAR: begin
          if (is_dec_s) begin state_s = GRF; cnt_s = 8'd1; grf_s = {3'b000, nibble_s}; end
          else          begin state_s = IDLE; end
        end
        GRF: begin
          if (is_dec_s && (cnt_r < GRF_MAX)) begin
            state_s = GRF;
            cnt_s   = cnt_r + 8'd1;
            grf_s   = grf_step(grf_r, nibble_s);
          end else if (char == CH_SPACE) begin state_s = GRF_SP;
          end else if (char == CH_LT)    begin state_s = LT;
          end else                       begin state_s = IDLE;
          end
        end
        GRF_SP, ADDR_SP: begin
          if (char == CH_SPACE)   begin state_s = state_r; end
          else if (char == CH_LT) begin state_s = LT; end
          else                    begin state_s = IDLE; end
        end
        STAR: begin
          if (is_hex_s) begin state_s = ADDR; cnt_s = 8'd1; addr_lo_s = nibble_s[1:0]; end
          else          begin state_s = IDLE; end
        end
        ADDR: begin
          // Only the last nibble's low bits matter for word alignment.
          if (is_hex_s && (cnt_r < ADDR_N)) begin
            state_s   = ADDR;
            cnt_s     = cnt_r + 8'd1;
            addr_lo_s = nibble_s[1:0];
          end else if ((char == CH_SPACE) && (cnt_r == ADDR_N)) begin state_s = ADDR_SP;
          end else if ((char == CH_LT) && (cnt_r == ADDR_N))    begin state_s = LT;
          end else                                              begin state_s = IDLE;
          end
        end
        LT: begin
          if (char == CH_EQ) begin state_s = EQ; end
          else               begin state_s = IDLE; end
        end
        EQ: begin
          if (char == CH_SPACE) begin state_s = EQ; end
          else if (is_hex_s)    begin state_s = DATA; cnt_s = 8'd1; end
          else                  begin state_s = IDLE; end
        end
        DATA: begin
          if (is_hex_s && (cnt_r < DATA_N))                     begin state_s = DATA; cnt_s = cnt_r + 8'd1; end
          else if ((char == CH_HASH) && (cnt_r == DATA_N))      begin state_s = END; end
          else                                                  begin state_s = IDLE; end
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // Semantic flags from the accumulated fields; irrelevant bits forced low.
  always_comb begin
    flags_s                 = 4'b0000;
    flags_s[ERR_PC_RANGE]   = (pc_r < PC_LO) || (pc_r > PC_HI);
    flags_s[ERR_PC_ALIGN]   = (pc_r[1:0] != 2'b00);
    flags_s[ERR_ADDR_ALIGN] = (type_r == FMT_MEM) && (addr_lo_r != 2'b00);
    flags_s[ERR_GRF]        = (type_r == FMT_REG) && (grf_r > 7'd31);
  end

  // State, accumulators, one-cycle result pulse and saturating line counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= 8'd0;
      pc_r      <= {PC_W{1'b0}};
      grf_r     <= 7'd0;
      addr_lo_r <= 2'b00;
      type_r    <= FMT_NONE;
      fmt_r     <= FMT_NONE;
      err_r     <= 4'b0000;
      count_r   <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      pc_r      <= pc_s;
      grf_r     <= grf_s;
      addr_lo_r <= addr_lo_s;
      type_r    <= type_s;
      if (state_s == END) begin
        fmt_r <= type_r;
        err_r <= flags_s;
        if ((type_r != FMT_NONE) && (flags_s == 4'b0000) && (count_r != {CNT_W{1'b1}})) begin
          count_r <= count_r + CNT_W'(1);
        end
      end else begin
        fmt_r <= FMT_NONE;
        err_r <= 4'b0000;
      end
    end
  end

  assign format_type = fmt_r;
  assign error_code  = err_r;
  assign line_count  = count_r;

endmodule
